// File: rtl/ofs_asp_pkg.sv
// ofs_asp_pkg
// Shared constants and types for the ASP slice: interrupt line counts, the
// bit position of each interrupt source, MMIO width, the interrupt-controller
// CSR word map, the interrupt vector type and the controller FSM states.
package ofs_asp_pkg;

  localparam int ASP_NUM_INTERRUPT_LINES = 4;
  localparam int ASP_NUM_IRQ_USED        = 3;
  localparam int ASP_MMIO_DATA_WIDTH     = 64;

  localparam int ASP_DMA_0_IRQ_BIT  = 0;
  localparam int ASP_KERNEL_IRQ_BIT = 1;
  localparam int ASP_DMA_1_IRQ_BIT  = 2;

  // CSR word addresses of the interrupt controller
  localparam int ASP_IRQ_CSR_STATUS    = 0;
  localparam int ASP_IRQ_CSR_PENDING   = 1;
  localparam int ASP_IRQ_CSR_MASK      = 2;
  localparam int ASP_IRQ_CSR_INSERVICE = 3;
  localparam int ASP_IRQ_CSR_CNT_BASE  = 4;

  typedef logic [ASP_NUM_INTERRUPT_LINES-1:0] t_irq_vec;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } t_irq_state;

endpackage

// File: rtl/ofs_asp_irq_rr_arb.sv
// ofs_asp_irq_rr_arb
// Combinational round-robin first-one finder. Searches req starting at
// index ptr and wrapping around; returns the first set index.
// Ports:
//   req         in   N      request vector
//   ptr         in   IDX_W  index where the search starts
//   grant_idx   out  IDX_W  first requesting index at or after ptr
//   grant_valid out  1      any request present
module ofs_asp_irq_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int j;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ofs_asp_irq_ctrl.sv
// ofs_asp_irq_ctrl
// Aggregates ASP interrupt sources (DMA_0, kernel, DMA_1) into one host
// interrupt request. Rising edges set sticky pending bits; a software mask
// gates them; one request at a time is raised with a vector index and held
// until the host acks. A 64-bit AVMM CSR slave exposes STATUS, PENDING (W1C),
// MASK and IN_SERVICE.
// Optional build macro: ASP_IRQ_EVENT_COUNTERS_EN adds per-line saturating
// rising-edge counters at CSR words 4+i (write any value to clear).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   irq_in               level-high source interrupts
//   irq_req, irq_id      host request and vector index
//   irq_ack              host accepted the current request
//   avs_*                AVMM CSR slave (1-cycle read latency, no wait states)
module ofs_asp_irq_ctrl
  import ofs_asp_pkg::*;
#(
  parameter int NUM_LINES      = ASP_NUM_INTERRUPT_LINES,
  parameter int NUM_USED       = ASP_NUM_IRQ_USED,
  parameter int CSR_DATA_WIDTH = ASP_MMIO_DATA_WIDTH,
  parameter int CSR_ADDR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LINES-1:0]          irq_in,
  output logic                          irq_req,
  output logic [$clog2(NUM_LINES)-1:0]  irq_id,
  input  logic                          irq_ack,
  input  logic [CSR_ADDR_WIDTH-1:0]     avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [CSR_DATA_WIDTH-1:0]     avs_writedata,
  input  logic [CSR_DATA_WIDTH/8-1:0]   avs_byteenable,
  output logic [CSR_DATA_WIDTH-1:0]     avs_readdata,
  output logic                          avs_readdatavalid,
  output logic                          avs_waitrequest
);

  localparam int ID_W = $clog2(NUM_LINES);
  localparam logic [NUM_LINES-1:0] USED_MASK =
    NUM_LINES'((64'd1 << NUM_USED) - 64'd1);

  logic [NUM_LINES-1:0]      irq_q;
  logic [NUM_LINES-1:0]      pending;
  logic [NUM_LINES-1:0]      mask;
  logic [NUM_LINES-1:0]      in_service;
  logic [NUM_LINES-1:0]      rise;
  logic [NUM_LINES-1:0]      w1c;
  logic [NUM_LINES-1:0]      eligible;
  logic [ID_W-1:0]           rr_ptr;
  logic [ID_W-1:0]           grant_idx;
  logic                      grant_valid;
  logic                      pend_wr;
  logic                      mask_wr;
  logic [CSR_DATA_WIDTH-1:0] rd_mux;
  t_irq_state                state;
  logic                      unused_csr_bits;

  assign avs_waitrequest = 1'b0;

  // All register fields live in byte 0, so only byteenable[0] matters for them.
  assign pend_wr = avs_write && avs_byteenable[0] &&
                   (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_PENDING));
  assign mask_wr = avs_write && avs_byteenable[0] &&
                   (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_MASK));
  assign w1c     = pend_wr ? avs_writedata[NUM_LINES-1:0] : '0;

  // Unused lines can never produce an event, so they never become pending.
  assign rise     = irq_in & ~irq_q & USED_MASK;
  assign eligible = pending & ~mask & ~in_service & USED_MASK;

  assign unused_csr_bits = ^{avs_writedata[CSR_DATA_WIDTH-1:NUM_LINES],
                             avs_byteenable[CSR_DATA_WIDTH/8-1:1]};

  ofs_asp_irq_rr_arb #(
    .N     (NUM_LINES),
    .IDX_W (ID_W)
  ) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Edge capture, sticky pending and the mask register. A rise in the same
  // cycle as a W1C of that bit keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~w1c) | rise;
      if (mask_wr) begin
        mask <= avs_writedata[NUM_LINES-1:0];
      end
    end
  end

  // Request FSM. The request is held regardless of later mask changes until
  // the host acks; the acked line then goes in service until software clears
  // its pending bit, and the round-robin pointer moves past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IRQ_IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      rr_ptr     <= '0;
      in_service <= '0;
    end else begin
      in_service <= in_service & ~w1c;
      case (state)
        IRQ_IDLE: begin
          if (grant_valid) begin
            irq_id  <= grant_idx;
            irq_req <= 1'b1;
            state   <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            in_service <= (in_service & ~w1c) | (NUM_LINES'(1) << irq_id);
            rr_ptr     <= (irq_id == ID_W'(NUM_LINES - 1)) ? '0 : irq_id + 1'b1;
            irq_req    <= 1'b0;
            state      <= IRQ_IDLE;
          end
        end
        default: begin
          state   <= IRQ_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASP_IRQ_EVENT_COUNTERS_EN
  logic [31:0] evt_cnt [NUM_USED];

  // Per-line saturating edge counters; a clearing write drops a coincident edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_USED; i++) begin
      if (reset) begin
        evt_cnt[i] <= '0;
      end else if (avs_write &&
                   avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_CNT_BASE + i)) begin
        evt_cnt[i] <= '0;
      end else if (rise[i] && evt_cnt[i] != 32'hFFFF_FFFF) begin
        evt_cnt[i] <= evt_cnt[i] + 32'd1;
      end
    end
  end
`endif

  // Read mux sees register values before any write in the same cycle.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      CSR_ADDR_WIDTH'(ASP_IRQ_CSR_STATUS):    rd_mux = CSR_DATA_WIDTH'(pending & ~mask);
      CSR_ADDR_WIDTH'(ASP_IRQ_CSR_PENDING):   rd_mux = CSR_DATA_WIDTH'(pending);
      CSR_ADDR_WIDTH'(ASP_IRQ_CSR_MASK):      rd_mux = CSR_DATA_WIDTH'(mask);
      CSR_ADDR_WIDTH'(ASP_IRQ_CSR_INSERVICE): rd_mux = CSR_DATA_WIDTH'(in_service);
      default: begin
`ifdef ASP_IRQ_EVENT_COUNTERS_EN
        for (int i = 0; i < NUM_USED; i++) begin
          if (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_CNT_BASE + i)) begin
            rd_mux = CSR_DATA_WIDTH'(evt_cnt[i]);
          end
        end
`else
        rd_mux = '0;
`endif
      end
    endcase
  end

  // Registered read response: one-cycle valid pulse after each read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_ofs_asp_irq_ctrl.sv
// tb_ofs_asp_irq_ctrl
// Directed bench for ofs_asp_irq_ctrl with a per-line behavioural model
// (arrays of pending/mask/in-service flags and an outstanding-request
// record) compared against the DUT every cycle, plus literal expectations.
// Honours ASP_IRQ_EVENT_COUNTERS_EN when the design is built with it.
module tb_ofs_asp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = '0;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [63:0] avs_writedata = '0;
  logic [7:0]  avs_byteenable = '0;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;

  int n_checks = 0;
  int n_pass = 0;
  bit checking = 1'b0;

  ofs_asp_irq_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .irq_req           (irq_req),
    .irq_id            (irq_id),
    .irq_ack           (irq_ack),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model state
  bit      m_prev  [4];
  bit      m_pend  [4];
  bit      m_mask  [4];
  bit      m_insvc [4];
  bit      m_req;
  int      m_id;
  int      m_ptr;
  bit      m_rdv;
  longint  m_rdata;
  longint  m_cnt [3];

  function automatic longint csrValue(input int addr);
    longint v;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      case (addr)
        0: if (m_pend[i] && !m_mask[i]) v += (64'd1 << i);
        1: if (m_pend[i])  v += (64'd1 << i);
        2: if (m_mask[i])  v += (64'd1 << i);
        3: if (m_insvc[i]) v += (64'd1 << i);
        default: ;
      endcase
    end
`ifdef ASP_IRQ_EVENT_COUNTERS_EN
    if (addr >= 4 && addr <= 6) v = m_cnt[addr-4];
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    bit rise [4];
    bit clr  [4];
    int grant;
    int acked;
    int idx;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 1; m_insvc[i] = 0;
      end
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_req = 0; m_id = 0; m_ptr = 0; m_rdv = 0; m_rdata = 0;
    end else begin
      m_rdv = avs_read;
      if (avs_read) m_rdata = csrValue(int'(avs_address));
      for (int i = 0; i < 4; i++) begin
        rise[i] = (i < 3) && irq_in[i] && !m_prev[i];
        clr[i]  = avs_write && avs_address == 3'd1 && avs_byteenable[0] && avs_writedata[i];
      end
      acked = -1;
      if (!m_req) begin
        grant = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (grant < 0 && idx < 3 && m_pend[idx] && !m_mask[idx] && !m_insvc[idx])
            grant = idx;
        end
        if (grant >= 0) begin
          m_req = 1;
          m_id  = grant;
        end
      end else if (irq_ack) begin
        acked = m_id;
        m_req = 0;
        m_ptr = (m_id + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr[i]) begin
          m_pend[i]  = 0;
          m_insvc[i] = 0;
        end
        if (rise[i]) m_pend[i] = 1;
      end
      if (acked >= 0) m_insvc[acked] = 1;
      if (avs_write && avs_address == 3'd2 && avs_byteenable[0])
        for (int i = 0; i < 4; i++) m_mask[i] = avs_writedata[i];
      for (int i = 0; i < 3; i++) begin
        if (avs_write && int'(avs_address) == 4 + i) m_cnt[i] = 0;
        else if (rise[i] && m_cnt[i] != 64'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
      end
      for (int i = 0; i < 4; i++) m_prev[i] = irq_in[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_irq_req", {63'd0, irq_req}, {63'd0, m_req});
      if (m_req) checkOutput("model_irq_id", {62'd0, irq_id}, 64'(m_id));
      checkOutput("model_rdvalid", {63'd0, avs_readdatavalid}, {63'd0, m_rdv});
      if (m_rdv) checkOutput("model_rdata", avs_readdata, m_rdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic ack);
    irq_in  = irq;
    irq_ack = ack;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic csrWrite(input int addr, input logic [63:0] data, input logic [7:0] be);
    avs_address    = 3'(addr);
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    tick();
    avs_write      = 1'b0;
  endtask

  task automatic csrRead(input int addr, output logic [63:0] data);
    avs_address = 3'(addr);
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic doReset;
    reset   = 1'b1;
    irq_in  = '0;
    irq_ack = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
  endtask

  logic [63:0] rd;

  initial begin
    $display("[TB] start");
    doReset();
    checking = 1'b1;

    // Reset state
    checkOutput("reset_irq_req", {63'd0, irq_req}, 64'd0);
    checkOutput("waitrequest", {63'd0, avs_waitrequest}, 64'd0);
    csrRead(2, rd);
    checkOutput("reset_mask", rd, 64'hF);
    csrRead(0, rd);
    checkOutput("reset_status", rd, 64'h0);

    // Single kernel interrupt: timing, hold without ack, ack
    csrWrite(2, 64'h0, 8'hFF);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("req_1_cycle_after_edge", {63'd0, irq_req}, 64'd0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("req_2_cycles_after_edge", {63'd0, irq_req}, 64'd1);
    checkOutput("req_id_kernel", {62'd0, irq_id}, 64'd1);
    for (int i = 0; i < 10; i++) applyStimulus(4'b0010, 1'b0);
    checkOutput("req_held_no_ack", {63'd0, irq_req}, 64'd1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("req_drop_after_ack", {63'd0, irq_req}, 64'd0);
    csrRead(3, rd);
    checkOutput("in_service_kernel", rd, 64'h2);

    // Simultaneous edges on lines 0 and 2 from a fresh pointer
    doReset();
    csrWrite(2, 64'h0, 8'hFF);
    applyStimulus(4'b0101, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("first_grant_line0", {61'd0, irq_req, irq_id}, 64'h4);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("second_grant_line2", {61'd0, irq_req, irq_id}, 64'h6);
    applyStimulus(4'b0000, 1'b1);
    csrRead(3, rd);
    checkOutput("in_service_0_2", rd, 64'h5);

    // New edge on line 0 coincident with W1C of pending bit 0
    irq_in = 4'b0001;
    csrWrite(1, 64'h1, 8'hFF);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("regrant_line0_wrap", {61'd0, irq_req, irq_id}, 64'h4);
    csrRead(1, rd);
    checkOutput("pending_set_wins", rd, 64'h5);
    applyStimulus(4'b0000, 1'b1);

    // Unused line 3 toggling
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
    end
    csrRead(1, rd);
    checkOutput("pending_bit3_clear", {63'd0, rd[3]}, 64'd0);
    checkOutput("no_req_line3", {63'd0, irq_req}, 64'd0);

    // Event counters (word 6 = line 2)
    csrWrite(6, 64'h0, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0000, 1'b0);
    end
    csrRead(6, rd);
`ifdef ASP_IRQ_EVENT_COUNTERS_EN
    checkOutput("counter_line2", rd, 64'd5);
    csrWrite(6, 64'h1234, 8'hFF);
    csrRead(6, rd);
    checkOutput("counter_cleared", rd, 64'd0);
`else
    checkOutput("word6_reads_zero", rd, 64'd0);
`endif
    csrRead(7, rd);
    checkOutput("word7_reads_zero", rd, 64'd0);

    // Reset while a request is outstanding
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("pre_reset_req", {61'd0, irq_req, irq_id}, 64'h5);
    reset = 1'b1;
    tick();
    checkOutput("req_cleared_by_reset", {63'd0, irq_req}, 64'd0);
    reset = 1'b0;
    tick();
    tick();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
